// File: rtl/hydra_tx_arbiter_if.sv
// hydra_tx_arbiter_if: requester handshake and shared UART tx bus of the tx arbiter
interface hydra_tx_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int NUM_REQ = 5
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [3:0] enable_piso;
  logic [3:0] tx_busy;
  logic [NUM_REQ-1:0] req_ready;
  logic [WIDTH-1:0] tx_data;
  logic [3:0] ld_tx_data;
  logic arb_busy;
  logic [15:0] sent_count;
  logic [15:0] drop_count;
  modport master (
    input req_valid, req_data, enable_piso, tx_busy,
    output req_ready, tx_data, ld_tx_data, arb_busy, sent_count, drop_count
  );
  modport slave (
    output req_valid, req_data, enable_piso, tx_busy,
    input req_ready, tx_data, ld_tx_data, arb_busy, sent_count, drop_count
  );
endinterface

// File: rtl/hydra_tx_arbiter.sv
// hydra_tx_arbiter: round-robin pick of one packet at a time, loaded into every enabled UART except the source port
module hydra_tx_arbiter #(
  parameter int WIDTH = 64,
  parameter int NUM_REQ = 5,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic reset,
  hydra_tx_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT_TX, LOAD, GUARD} state_t;
  state_t state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic [TW-1:0] timer;
  logic [3:0] target;
  logic tx_free;
  logic timed_out;
  // Walk downward so the nearest requester after last_grant is the last one written
  always_comb begin
    win = last_grant;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      win = bus.req_valid[cand] ? cand : win;
    end
  end
  assign tx_free = (bus.tx_busy & target) == 4'd0;
  assign timed_out = timer == TW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      timer <= '0;
      target <= '0;
      bus.tx_data <= '0;
      bus.req_ready <= '0;
      bus.ld_tx_data <= '0;
      bus.arb_busy <= 1'b0;
      bus.sent_count <= '0;
      bus.drop_count <= '0;
    end else begin
      bus.req_ready <= '0;
      bus.ld_tx_data <= '0;
      case (state)
        IDLE: if (|bus.req_valid) begin
          state <= WAIT_TX;
          bus.arb_busy <= 1'b1;
          last_grant <= win;
          bus.req_ready <= NUM_REQ'(1) << win;
          bus.tx_data <= bus.req_data[int'(win) * WIDTH +: WIDTH];
          // Never echo a packet back to the rx port it came from; the local FIFO index shifts out to zero
          target <= bus.enable_piso & ~(4'd1 << win);
        end
        WAIT_TX: if (tx_free && target != 4'd0) begin
          state <= LOAD;
          timer <= '0;
          bus.ld_tx_data <= target;
          bus.sent_count <= bus.sent_count + 16'(~&bus.sent_count);
        end else if (target == 4'd0 || timed_out) begin
          state <= IDLE;
          bus.arb_busy <= 1'b0;
          timer <= '0;
          bus.drop_count <= bus.drop_count + 16'(~&bus.drop_count);
        end else begin
          timer <= timer + TW'(1);
        end
        LOAD: state <= GUARD;
        GUARD: begin
          state <= IDLE;
          bus.arb_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hydra_tx_arbiter.sv
// tb_hydra_tx_arbiter: directed scenarios with a grant scoreboard checked against the arbiter outputs
module tb_hydra_tx_arbiter;
  typedef struct {
    int g;
    logic [63:0] d;
    logic [3:0] ld;
  } exp_t;
  logic clk;
  logic reset;
  exp_t sb[$];
  exp_t e;
  int gcyc[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ld_cyc = 0;
  int fall_cyc = 0;
  bit lat_chk = 0;
  logic [3:0] cur_ld = '0;
  logic [63:0] cur_d = '0;
  logic [15:0] exp_sent = '0;
  logic [15:0] exp_drop = '0;
  hydra_tx_arbiter_if #(.WIDTH(64), .NUM_REQ(5)) bus ();
  hydra_tx_arbiter #(.WIDTH(64), .NUM_REQ(5), .TIMEOUT(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (bus.req_ready != '0) begin
        if (sb.size() == 0) chk("spurious_grant", 64'(bus.req_ready), 64'd0);
        else begin
          e = sb.pop_front();
          chk("grant", 64'(bus.req_ready), 64'(1) << e.g);
          chk("tx_data", bus.tx_data, e.d);
          cur_ld = e.ld;
          cur_d = e.d;
          gcyc.push_back(cyc);
        end
      end
      if (bus.ld_tx_data != '0) begin
        chk("ld_tx_data", 64'(bus.ld_tx_data), 64'(cur_ld));
        chk("tx_data_at_ld", bus.tx_data, cur_d);
        if (lat_chk) chk("ld_latency", 64'(cyc - gcyc[$]), 64'd1);
        ld_cyc = cyc;
        cur_ld = '0;
      end
    end
  endtask
  task automatic run_until_empty(input int limit);
    for (int k = 0; k < limit && sb.size() != 0; k++) run(1);
    if (sb.size() != 0) chk("grant_timeout", 64'(sb.size()), 64'd0);
  endtask
  task automatic push(input int g, input logic [63:0] d, input logic [3:0] ld);
    exp_t x;
    x.g = g;
    x.d = d;
    x.ld = ld;
    sb.push_back(x);
  endtask
  task automatic chk_counts(input string tag);
    chk({tag, "_sent"}, 64'(bus.sent_count), 64'(exp_sent));
    chk({tag, "_drop"}, 64'(bus.drop_count), 64'(exp_drop));
  endtask
  function automatic logic [15:0] sat(input logic [15:0] v);
    return v == 16'hFFFF ? v : v + 16'd1;
  endfunction
  initial begin
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.enable_piso = '0;
    bus.tx_busy = '0;
    run(2);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_ld", 64'(bus.ld_tx_data), 64'd0);
    chk("rst_arb_busy", 64'(bus.arb_busy), 64'd0);
    chk("rst_tx_data", bus.tx_data, 64'd0);
    chk_counts("rst");
    reset = 1'b0;
    run(1);
    // Round robin with everyone requesting and all ports idle
    lat_chk = 1;
    for (int i = 0; i < 5; i++) bus.req_data[i*64 +: 64] = 64'h1000 + 64'(i);
    bus.enable_piso = 4'b1111;
    bus.req_valid = 5'b11111;
    gcyc.delete();
    for (int i = 0; i < 6; i++) begin
      push(i % 5, 64'h1000 + 64'(i % 5), (i % 5) == 4 ? 4'b1111 : 4'b1111 & ~(4'd1 << (i % 5)));
      exp_sent = sat(exp_sent);
    end
    run_until_empty(40);
    bus.req_valid = '0;
    run(4);
    for (int k = 1; k < 6; k++) chk("rr_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'd4);
    chk_counts("rr");
    // No echo to the source port; valid drops before the grant is seen
    bus.req_data[2*64 +: 64] = 64'hA5;
    bus.req_valid = 5'b00100;
    push(2, 64'hA5, 4'b1011);
    exp_sent = sat(exp_sent);
    run(1);
    bus.req_valid = '0;
    run(5);
    chk_counts("noecho");
    // Local packet waits for a busy UART
    lat_chk = 0;
    bus.enable_piso = 4'b0001;
    bus.tx_busy = 4'b0001;
    bus.req_data[4*64 +: 64] = 64'hBEEF;
    run(3);
    bus.req_valid = 5'b10000;
    push(4, 64'hBEEF, 4'b0001);
    exp_sent = sat(exp_sent);
    run(1);
    bus.req_valid = '0;
    run(6);
    bus.tx_busy = '0;
    fall_cyc = cyc;
    run(4);
    chk("busy_ld_delay", 64'(ld_cyc - fall_cyc), 64'd1);
    chk_counts("busy");
    // Stuck UART drops the packet after TIMEOUT wait cycles
    bus.tx_busy = 4'b0001;
    bus.req_data[4*64 +: 64] = 64'hD00D;
    bus.req_valid = 5'b10000;
    push(4, 64'hD00D, 4'b0000);
    run(1);
    bus.req_valid = '0;
    run(7);
    chk("timeout_still_busy", 64'(bus.arb_busy), 64'd1);
    run(1);
    chk("timeout_idle", 64'(bus.arb_busy), 64'd0);
    exp_drop = sat(exp_drop);
    chk_counts("timeout");
    bus.tx_busy = '0;
    run(2);
    // Only the source port enabled: nothing to send
    bus.req_data[0*64 +: 64] = 64'h0C0C;
    bus.req_valid = 5'b00001;
    push(0, 64'h0C0C, 4'b0000);
    run(1);
    bus.req_valid = '0;
    run(1);
    chk("notarget_idle", 64'(bus.arb_busy), 64'd0);
    exp_drop = sat(exp_drop);
    run(2);
    chk_counts("notarget");
    // Reset while waiting aborts the packet
    bus.enable_piso = 4'b1111;
    bus.tx_busy = 4'b1111;
    bus.req_data[1*64 +: 64] = 64'h1001;
    bus.req_valid = 5'b00010;
    push(1, 64'h1001, 4'b0000);
    run(1);
    bus.req_valid = '0;
    reset = 1'b1;
    run(1);
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("midrst_ld", 64'(bus.ld_tx_data), 64'd0);
    chk("midrst_arb_busy", 64'(bus.arb_busy), 64'd0);
    chk("midrst_tx_data", bus.tx_data, 64'd0);
    exp_sent = '0;
    exp_drop = '0;
    chk_counts("midrst");
    reset = 1'b0;
    bus.tx_busy = '0;
    run(3);
    // After reset the search restarts at requester 0
    lat_chk = 1;
    bus.req_valid = 5'b00110;
    push(1, 64'h1001, 4'b1101);
    exp_sent = sat(exp_sent);
    run(1);
    bus.req_valid = '0;
    run(4);
    chk_counts("postrst");
    // Saturation of both counters
    force bus.sent_count = 16'hFFFE;
    #1 release bus.sent_count;
    exp_sent = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      bus.req_data[4*64 +: 64] = 64'h5A00 + 64'(i);
      bus.req_valid = 5'b10000;
      push(4, 64'h5A00 + 64'(i), 4'b1111);
      exp_sent = sat(exp_sent);
      run(1);
      bus.req_valid = '0;
      run(4);
    end
    force bus.drop_count = 16'hFFFF;
    #1 release bus.drop_count;
    exp_drop = 16'hFFFF;
    bus.enable_piso = 4'b0000;
    bus.req_valid = 5'b10000;
    push(4, 64'h5A01, 4'b0000);
    exp_drop = sat(exp_drop);
    run(1);
    bus.req_valid = '0;
    run(3);
    chk_counts("sat");
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
